// File: rtl/core_muldiv.sv
// core_muldiv: multi-cycle RV32M multiply/divide unit for the EX stage.
// Iterative radix-2 shift-add multiply and restoring shift-subtract divide,
// one bit per cycle, result returned with a one-cycle o_done pulse.
// Optional macro CORE_MULDIV_FAST_MUL_EN: multiplies use a single-cycle
// 33x33 signed multiplier instead of the iterative path.
module core_muldiv #(
    parameter int XLEN  = 32,
    parameter int CNT_W = 5
) (
    input  logic            clk,
    input  logic            rstn,
    input  logic            i_start,
    input  logic            i_flush,
    input  logic [2:0]      i_funct3,
    input  logic [XLEN-1:0] i_num1u,
    input  logic [XLEN-1:0] i_num2u,
    output logic            o_stall,
    output logic            o_done,
    output logic [XLEN-1:0] o_res
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_CALC = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    state_t                state_r;
    state_t                state_nx_s;
    logic [CNT_W-1:0]      cnt_r;
    logic [2:0]            funct3_r;
    logic                  neg_r;
    logic [XLEN-1:0]       opb_r;       // multiplicand or divisor magnitude
    logic [2*XLEN-1:0]     acc_r;       // {acc/remainder, multiplier/quotient}
    logic [XLEN-1:0]       res_r;

    logic                  start_s;
    logic                  is_div_s;
    logic                  s1_s, s2_s, neg1_s, neg2_s, sign_s;
    logic [XLEN-1:0]       mag1_s, mag2_s;
    logic                  div0_s, ovf_s, special_s;
    logic [XLEN-1:0]       special_res_s;
    logic                  fast_s;
    logic [XLEN-1:0]       fast_res_s;
    logic [XLEN:0]         mul_sum_s;
    logic [XLEN:0]         div_trial_s;
    logic [2*XLEN-1:0]     acc_nx_s;
    logic [2*XLEN-1:0]     prod_s;
    logic [XLEN-1:0]       quo_s, rem_s;
    logic [XLEN-1:0]       calc_res_s;
    logic                  last_s;

    assign start_s  = (state_r == ST_IDLE) && i_start && !i_flush;
    assign is_div_s = i_funct3[2];
    assign last_s   = (cnt_r == {CNT_W{1'b1}});

    // Operand signedness, magnitudes, result sign and special-case detection
    always_comb begin
        s1_s   = (i_funct3 == 3'b001) || (i_funct3 == 3'b010) ||
                 (i_funct3 == 3'b100) || (i_funct3 == 3'b110);
        s2_s   = (i_funct3 == 3'b001) || (i_funct3 == 3'b100) ||
                 (i_funct3 == 3'b110);
        neg1_s = s1_s && i_num1u[XLEN-1];
        neg2_s = s2_s && i_num2u[XLEN-1];
        mag1_s = neg1_s ? (~i_num1u + 32'd1) : i_num1u;
        mag2_s = neg2_s ? (~i_num2u + 32'd1) : i_num2u;
        case (i_funct3)
            3'b001:  sign_s = neg1_s ^ neg2_s;
            3'b010:  sign_s = neg1_s;
            3'b100:  sign_s = neg1_s ^ neg2_s;
            3'b110:  sign_s = neg1_s;
            default: sign_s = 1'b0;
        endcase
        div0_s    = is_div_s && (i_num2u == 32'd0);
        ovf_s     = ((i_funct3 == 3'b100) || (i_funct3 == 3'b110)) &&
                    (i_num1u == 32'h8000_0000) && (i_num2u == 32'hFFFF_FFFF);
        special_s = div0_s || ovf_s;
        if (div0_s) begin
            special_res_s = i_funct3[1] ? i_num1u : 32'hFFFF_FFFF;
        end else begin
            special_res_s = i_funct3[1] ? 32'd0 : 32'h8000_0000;
        end
    end

`ifdef CORE_MULDIV_FAST_MUL_EN
    logic [2*XLEN-1:0] fa_s, fb_s, fprod_s;
    // Single-cycle signed multiply; 33-bit operands sign-extended to 64 bits
    always_comb begin
        fa_s       = {{(XLEN-1){s1_s && i_num1u[XLEN-1]}}, s1_s && i_num1u[XLEN-1], i_num1u};
        fb_s       = {{(XLEN-1){s2_s && i_num2u[XLEN-1]}}, s2_s && i_num2u[XLEN-1], i_num2u};
        fprod_s    = fa_s * fb_s;
        fast_s     = !is_div_s;
        if (i_funct3 == 3'b000) begin
            fast_res_s = fprod_s[XLEN-1:0];
        end else begin
            fast_res_s = fprod_s[2*XLEN-1:XLEN];
        end
    end
`else
    assign fast_s     = 1'b0;
    assign fast_res_s = 32'd0;
`endif

    // One radix-2 iteration plus final sign correction and result select
    always_comb begin
        mul_sum_s   = {1'b0, acc_r[2*XLEN-1:XLEN]} + ({1'b0, opb_r} & {(XLEN+1){acc_r[0]}});
        div_trial_s = acc_r[2*XLEN-1:XLEN-1] - {1'b0, opb_r};
        if (funct3_r[2]) begin
            if (div_trial_s[XLEN]) begin
                acc_nx_s = {acc_r[2*XLEN-2:0], 1'b0};
            end else begin
                acc_nx_s = {div_trial_s[XLEN-1:0], acc_r[XLEN-2:0], 1'b1};
            end
        end else begin
            acc_nx_s = {mul_sum_s, acc_r[XLEN-1:1]};
        end
        prod_s = neg_r ? (~acc_nx_s + 64'd1) : acc_nx_s;
        quo_s  = neg_r ? (~acc_nx_s[XLEN-1:0] + 32'd1) : acc_nx_s[XLEN-1:0];
        rem_s  = neg_r ? (~acc_nx_s[2*XLEN-1:XLEN] + 32'd1) : acc_nx_s[2*XLEN-1:XLEN];
        case (funct3_r)
            3'b000:  calc_res_s = prod_s[XLEN-1:0];
            3'b001,
            3'b010,
            3'b011:  calc_res_s = prod_s[2*XLEN-1:XLEN];
            3'b100,
            3'b101:  calc_res_s = quo_s;
            default: calc_res_s = rem_s;
        endcase
    end

    // FSM state register
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_nx_s;
        end
    end

    // FSM next-state logic; flush returns to IDLE from any state
    always_comb begin
        state_nx_s = ST_IDLE;
        case (state_r)
            ST_IDLE: begin
                if (start_s) begin
                    state_nx_s = (special_s || fast_s) ? ST_DONE : ST_CALC;
                end else begin
                    state_nx_s = ST_IDLE;
                end
            end
            ST_CALC: begin
                if (i_flush) begin
                    state_nx_s = ST_IDLE;
                end else if (last_s) begin
                    state_nx_s = ST_DONE;
                end else begin
                    state_nx_s = ST_CALC;
                end
            end
            ST_DONE: state_nx_s = ST_IDLE;
            default: state_nx_s = ST_IDLE;
        endcase
    end

    // FSM outputs: stall while accepting or iterating, done pulse masked by flush
    always_comb begin
        o_stall = 1'b0;
        o_done  = 1'b0;
        case (state_r)
            ST_IDLE: o_stall = start_s;
            ST_CALC: o_stall = 1'b1;
            ST_DONE: o_done  = !i_flush;
            default: begin
                o_stall = 1'b0;
                o_done  = 1'b0;
            end
        endcase
    end

    // Datapath: operand capture, iteration, result register
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            cnt_r    <= {CNT_W{1'b0}};
            funct3_r <= 3'd0;
            neg_r    <= 1'b0;
            opb_r    <= 32'd0;
            acc_r    <= 64'd0;
            res_r    <= 32'd0;
        end else begin
            if (start_s) begin
                funct3_r <= i_funct3;
                neg_r    <= sign_s;
                cnt_r    <= {CNT_W{1'b0}};
                if (is_div_s) begin
                    acc_r <= {32'd0, mag1_s};
                    opb_r <= mag2_s;
                end else begin
                    acc_r <= {32'd0, mag2_s};
                    opb_r <= mag1_s;
                end
                if (special_s) begin
                    res_r <= special_res_s;
                end else if (fast_s) begin
                    res_r <= fast_res_s;
                end
            end else if ((state_r == ST_CALC) && !i_flush) begin
                acc_r <= acc_nx_s;
                cnt_r <= cnt_r + 5'd1;
                if (last_s) begin
                    res_r <= calc_res_s;
                end
            end
        end
    end

    assign o_res = res_r;

endmodule

// File: tb/tb_core_muldiv.sv
// Directed self-checking bench for core_muldiv: vector table plus
// hand-written flush and reset sequences.
module tb_core_muldiv;

`ifdef CORE_MULDIV_FAST_MUL_EN
    localparam int MLAT = 1;
`else
    localparam int MLAT = 33;
`endif
    localparam int NV = 18;

    logic        clk = 1'b0;
    logic        rstn = 1'b0;
    logic        i_start = 1'b0;
    logic        i_flush = 1'b0;
    logic [2:0]  i_funct3 = 3'd0;
    logic [31:0] i_num1u = 32'd0;
    logic [31:0] i_num2u = 32'd0;
    logic        o_stall;
    logic        o_done;
    logic [31:0] o_res;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [2:0]  f;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] res;
        int          lat;
        string       nm;
    } vec_t;

    vec_t vecs [0:NV-1];

    core_muldiv dut (
        .clk      (clk),
        .rstn     (rstn),
        .i_start  (i_start),
        .i_flush  (i_flush),
        .i_funct3 (i_funct3),
        .i_num1u  (i_num1u),
        .i_num2u  (i_num2u),
        .o_stall  (o_stall),
        .o_done   (o_done),
        .o_res    (o_res)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    // Issue one op at cycle 0 and watch stall/done until completion
    task automatic run_op(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b,
                          input logic [31:0] exp, input int lat, input string nm);
        int got_lat = -1;
        int stall_bad = 0;
        @(negedge clk);
        i_funct3 = f; i_num1u = a; i_num2u = b; i_start = 1'b1;
        #1;
        if (o_stall !== 1'b1) stall_bad++;
        for (int c = 1; c <= 60; c++) begin
            @(negedge clk);
            i_start = 1'b0;
            #1;
            if (o_done === 1'b1) begin
                got_lat = c;
                if (o_stall !== 1'b0) stall_bad++;
                break;
            end else if (o_stall !== 1'b1) begin
                stall_bad++;
            end
        end
        chk({nm, " latency"}, got_lat, lat);
        chk({nm, " stall"}, stall_bad, 0);
        chk({nm, " result"}, o_res, exp);
    endtask

    initial begin
        int seen_done;
        logic [31:0] last_res;

        vecs[0]  = '{3'b000, 32'd7,          32'hFFFF_FFFD, 32'hFFFF_FFEB, MLAT, "mul 7*-3"};
        vecs[1]  = '{3'b011, 32'hFFFF_FFFF,  32'hFFFF_FFFF, 32'hFFFF_FFFE, MLAT, "mulhu max"};
        vecs[2]  = '{3'b001, 32'h8000_0000,  32'h8000_0000, 32'h4000_0000, MLAT, "mulh min*min"};
        vecs[3]  = '{3'b010, 32'hFFFF_FFFF,  32'hFFFF_FFFF, 32'hFFFF_FFFF, MLAT, "mulhsu -1*max"};
        vecs[4]  = '{3'b000, 32'h0000_FFFF,  32'h0001_0001, 32'hFFFF_FFFF, MLAT, "mul ffff*10001"};
        vecs[5]  = '{3'b011, 32'h0001_0000,  32'h0001_0000, 32'h0000_0001, MLAT, "mulhu 2^16*2^16"};
        vecs[6]  = '{3'b001, 32'hFFFF_FFFF,  32'hFFFF_FFFF, 32'h0000_0000, MLAT, "mulh -1*-1"};
        vecs[7]  = '{3'b001, 32'hFFFF_FFFF,  32'd1,         32'hFFFF_FFFF, MLAT, "mulh -1*1"};
        vecs[8]  = '{3'b100, 32'hFFFF_FFF9,  32'd2,         32'hFFFF_FFFD, 33,   "div -7/2"};
        vecs[9]  = '{3'b110, 32'hFFFF_FFF9,  32'd2,         32'hFFFF_FFFF, 33,   "rem -7/2"};
        vecs[10] = '{3'b101, 32'd100,        32'd7,         32'd14,        33,   "divu 100/7"};
        vecs[11] = '{3'b100, 32'hFFFF_FFF9,  32'hFFFF_FFFE, 32'd3,         33,   "div -7/-2"};
        vecs[12] = '{3'b110, 32'd7,          32'hFFFF_FFFE, 32'd1,         33,   "rem 7/-2"};
        vecs[13] = '{3'b101, 32'h0000_1234,  32'd0,         32'hFFFF_FFFF, 1,    "divu by 0"};
        vecs[14] = '{3'b111, 32'h0000_1234,  32'd0,         32'h0000_1234, 1,    "remu by 0"};
        vecs[15] = '{3'b100, 32'h8000_0000,  32'hFFFF_FFFF, 32'h8000_0000, 1,    "div overflow"};
        vecs[16] = '{3'b110, 32'h8000_0000,  32'hFFFF_FFFF, 32'd0,         1,    "rem overflow"};
        vecs[17] = '{3'b110, 32'hFFFF_FFFB,  32'd0,         32'hFFFF_FFFB, 1,    "rem -5/0"};

        // Reset state
        repeat (2) @(negedge clk);
        #1;
        chk("reset res", o_res, 32'd0);
        chk("reset done", {31'd0, o_done}, 32'd0);
        chk("reset stall", {31'd0, o_stall}, 32'd0);
        @(negedge clk);
        rstn = 1'b1;

        // Vector table, issued back-to-back
        for (int i = 0; i < NV; i++) begin
            run_op(vecs[i].f, vecs[i].a, vecs[i].b, vecs[i].res, vecs[i].lat, vecs[i].nm);
        end
        last_res = vecs[NV-1].res;

        // Flush in CALC: no done, IDLE next cycle, result untouched
        seen_done = 0;
        @(negedge clk);
        i_funct3 = 3'b100; i_num1u = 32'd1000; i_num2u = 32'd7; i_start = 1'b1;
        for (int c = 1; c <= 10; c++) begin
            @(negedge clk);
            i_start = 1'b0;
            if (c == 10) i_flush = 1'b1;
            #1;
            if (o_done === 1'b1) seen_done++;
        end
        @(negedge clk);
        i_flush = 1'b0;
        #1;
        chk("flush idle stall", {31'd0, o_stall}, 32'd0);
        chk("flush res kept", o_res, last_res);
        for (int c = 0; c < 40; c++) begin
            @(negedge clk);
            #1;
            if (o_done === 1'b1) seen_done++;
        end
        chk("flush no done", seen_done, 0);
        run_op(3'b111, 32'd10, 32'd3, 32'd1, 33, "remu 10/3");

        // Flush on the DONE cycle masks the pulse
        @(negedge clk);
        i_funct3 = 3'b101; i_num1u = 32'd100; i_num2u = 32'd7; i_start = 1'b1;
        for (int c = 1; c <= 32; c++) begin
            @(negedge clk);
            i_start = 1'b0;
        end
        @(negedge clk);
        i_flush = 1'b1;
        #1;
        chk("done masked", {31'd0, o_done}, 32'd0);
        @(negedge clk);
        i_flush = 1'b0;

        // Asynchronous reset mid-multiply
        seen_done = 0;
        @(negedge clk);
        i_funct3 = 3'b000; i_num1u = 32'd3; i_num2u = 32'd5; i_start = 1'b1;
        for (int c = 1; c <= 15; c++) begin
            @(negedge clk);
            i_start = 1'b0;
        end
        rstn = 1'b0;
        #1;
        chk("async rst res", o_res, 32'd0);
        chk("async rst done", {31'd0, o_done}, 32'd0);
        chk("async rst stall", {31'd0, o_stall}, 32'd0);
        @(negedge clk);
        rstn = 1'b1;
        for (int c = 0; c < 40; c++) begin
            @(negedge clk);
            #1;
            if (o_done === 1'b1) seen_done++;
        end
        chk("rst no done", seen_done, 0);
        run_op(3'b000, 32'd3, 32'd5, 32'd15, MLAT, "mul after reset");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/core_muldiv.md
Name: core_muldiv

Overview:
- Multi-cycle RV32M execution unit that sits beside the single-cycle integer ALU in the EX stage.
- The decoder raises i_start for OP-opcode instructions with funct7=0000001. The block then stalls the pipeline while an iterative shift-add/shift-subtract datapath runs.
- It returns one result with a single-cycle o_done pulse, so writeback can mux it in place of the ALU result.

Parameters:
XLEN, 32, operand/result width; only 32 is supported.
CNT_W, 5, iteration counter width; equals log2(XLEN).

Ports:
clk  input  1  core clock; all state updates on rising edge
rstn  input  1  asynchronous active-low reset
i_start  input  1  EX holds a valid M instruction; sampled only in IDLE
i_flush  input  1  pipeline flush; aborts any operation in progress
i_funct3  input  3  000 MUL, 001 MULH, 010 MULHSU, 011 MULHU, 100 DIV, 101 DIVU, 110 REM, 111 REMU
i_num1u  input  32  rs1 value (dividend / multiplicand)
i_num2u  input  32  rs2 value (divisor / multiplier)
o_stall  output  1  freeze PC/IF/ID/EX this cycle
o_done  output  1  o_res is valid this cycle; one-cycle pulse
o_res  output  32  result register

Behaviour:
- Reset (rstn=0, asynchronous): state=IDLE, counter=0, all internal registers 0, o_res=0, o_done=0. Reset mid-operation discards the operation; no o_done follows.
- States: IDLE, CALC, DONE.
- IDLE with i_start=1 and i_flush=0: latch funct3 and the operands.
  - Signed ops (MULH, MULHSU-rs1, DIV, REM) convert signed operands to magnitudes and record the result sign.
  - Next state is CALC with counter=0, unless a special case applies.
- Special cases go IDLE->DONE directly; o_res is written at that edge:
  - Divisor 0: DIV and DIVU give 0xFFFFFFFF; REM and REMU give the dividend.
  - DIV 0x80000000 / 0xFFFFFFFF gives 0x80000000; the matching REM gives 0.
- CALC: one radix-2 iteration per cycle.
  - Multiply: 64-bit partial-product accumulate, shift right.
  - Divide: restoring shift-subtract; quotient bit = no-borrow.
  - At the edge where counter==31: apply sign correction, write o_res, go to DONE.
  - Sign rules: quotient negated if operand signs differ; remainder takes the dividend's sign; signed products take the two's complement of the 64-bit product.
  - o_res selects product[31:0] for MUL and product[63:32] for MULH, MULHSU and MULHU.
- DONE: o_done = 1 & ~i_flush. Next state is IDLE unconditionally. o_res holds its value until the next write.
- o_stall = (state==IDLE & i_start & ~i_flush) | (state==CALC). It is low in DONE, so EX advances on the o_done cycle.
- Latency, with the i_start cycle as cycle 0:
  - Normal op: CALC in cycles 1..32, o_done in cycle 33.
  - Special case: o_done in cycle 1.
- i_start in CALC or DONE is ignored; the pipeline is stalled then, so it cannot legally occur.
- Back-to-back ops: a new i_start may be presented in the cycle after DONE.
- i_flush in any state forces IDLE at the next edge. It masks o_done combinationally and leaves o_res unchanged. If i_flush and i_start arrive together in IDLE, the flush wins.

Optional Feature:
- Macro: CORE_MULDIV_FAST_MUL_EN.
- Defined: MUL, MULH, MULHSU and MULHU use a single 33x33 signed multiplier. The result is registered at the IDLE edge, the block goes straight to DONE (o_done in cycle 1), and o_stall is asserted only in cycle 0.
- Divide behaviour is unchanged.
- Undefined: all multiplies use the iterative CALC path with 33-cycle latency.

Test Plan:
- MUL 7 x 0xFFFFFFFD: o_stall high cycles 0..32, o_done cycle 33, o_res=0xFFFFFFEB (1 cycle with FAST_MUL).
- MULHU 0xFFFFFFFF x 0xFFFFFFFF -> 0xFFFFFFFE; MULH 0x80000000 x 0x80000000 -> 0x40000000; MULHSU 0xFFFFFFFF x 0xFFFFFFFF -> 0xFFFFFFFF.
- DIV 0xFFFFFFF9 / 2 -> 0xFFFFFFFD and REM -> 0xFFFFFFFF, each o_done at cycle 33. Then an immediate back-to-back DIVU 100/7 -> 14.
- DIVU 0x1234/0 -> 0xFFFFFFFF, REMU 0x1234/0 -> 0x1234, DIV 0x80000000/0xFFFFFFFF -> 0x80000000, REM of the same -> 0: each o_done at cycle 1.
- DIV starts, then i_flush in cycle 10: no o_done, state IDLE at cycle 11, o_res unchanged. A following REMU 10/3 -> 1.
- rstn pulsed low in cycle 15 of a MUL: o_res=0, o_done=0, o_stall=0 immediately and asynchronously. No o_done after release.
